// File: rtl/bcd_seq_convert_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_seq_convert_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned ADD3_THRESHOLD = 5;
  localparam int unsigned ADD3_VALUE     = 3;

  // Step counter must hold values 0..bin_w.
  function automatic int unsigned cnt_width(input int unsigned bin_w);
    return $clog2(bin_w + 1);
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left by one.
module bcd_dabble_step
  import bcd_seq_convert_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 8
) (
  input  logic [BCD_DIGIT_W*DIGITS+BIN_W-1:0] sr_in,
  output logic [BCD_DIGIT_W*DIGITS+BIN_W-1:0] sr_out
);

  localparam int unsigned SR_W = BCD_DIGIT_W * DIGITS + BIN_W;

  logic [SR_W-1:0]        corr;
  logic [BCD_DIGIT_W-1:0] nib;

  always_comb begin
    corr = sr_in;
    nib  = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      nib = sr_in[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W];
      if (nib >= BCD_DIGIT_W'(ADD3_THRESHOLD))
        corr[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] = nib + BCD_DIGIT_W'(ADD3_VALUE);
    end
    sr_out = corr << 1;
  end

endmodule

// File: rtl/bcd_seq_convert.sv
// Sequential binary-to-BCD converter: accepts a value, runs BIN_W dabble steps, hands off packed digits.
module bcd_seq_convert
  import bcd_seq_convert_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [BIN_W-1:0]              i_bin,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = cnt_width(BIN_W);

  if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_digits_too_few
    $error("bcd_seq_convert: DIGITS too small for BIN_W");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d, step_out;
  logic             valid_d;
  logic [BCD_W-1:0] bcd_d;

  bcd_dabble_step #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_step (
    .sr_in  (sr_q),
    .sr_out (step_out)
  );

  assign o_ready = (state_q == IDLE) && !i_rst;

  // Next-state and datapath decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    valid_d = o_valid;
    bcd_d   = o_bcd;
    case (state_q)
      IDLE: begin
        if (i_valid && o_ready) begin
          sr_d    = SR_W'(i_bin);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = step_out;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_d   = step_out[SR_W-1 -: BCD_W];
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      o_valid <= 1'b0;
      o_bcd   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      o_valid <= valid_d;
      o_bcd   <= bcd_d;
    end
  end

endmodule

// File: tb/tb_bcd_seq_convert.sv
// Directed self-checking bench for bcd_seq_convert (BIN_W=8, DIGITS=3).
module tb_bcd_seq_convert;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [7:0]  i_bin = 8'd0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [11:0] o_bcd;

  int checks = 0;
  int failures = 0;

  bcd_seq_convert #(.BIN_W(8), .DIGITS(3)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_bin   (i_bin),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_bcd   (o_bcd)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Waits for o_ready, submits v, returns the result and clocks from acceptance to o_valid.
  task automatic run_conv(input logic [7:0] v, output logic [11:0] bcd, output int lat);
    int w;
    w = 0;
    lat = -1;
    bcd = 12'hfff;
    while (!o_ready && w < 30) begin
      tick();
      w++;
    end
    if (!o_ready) begin
      checks++;
      failures++;
      $display("FAIL run_conv_ready_timeout value=%0d o_ready=%b required=1", v, o_ready);
      return;
    end
    i_bin = v;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_bin = ~v;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (o_valid) begin
        lat = k;
        bcd = o_bcd;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL run_conv_valid_timeout value=%0d o_valid=%b required=1", v, o_valid);
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    tick();
    tick();
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
    checks++;
    if (o_bcd !== 12'h000) begin failures++; $display("FAIL reset_o_bcd got=%h exp=000", o_bcd); end
    checks++;
    if (o_ready !== 1'b0) begin failures++; $display("FAIL reset_o_ready_in_reset got=%b exp=0", o_ready); end
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready_released got=%b exp=1", o_ready); end
  endtask

  task automatic test_first_255;
    int lat;
    lat = -1;
    i_ready = 1'b1;
    i_bin = 8'd255;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0) begin failures++; $display("FAIL first_ready_drop got=%b exp=0", o_ready); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (o_valid) begin lat = k; break; end
    end
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL first_latency got=%0d exp=8", lat); end
    checks++;
    if (o_bcd !== 12'h255) begin failures++; $display("FAIL first_bcd got=%h exp=255", o_bcd); end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL first_valid_clear got=%b exp=0", o_valid); end
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL first_ready_return got=%b exp=1", o_ready); end
    checks++;
    if (o_bcd !== 12'h255) begin failures++; $display("FAIL first_bcd_held got=%h exp=255", o_bcd); end
  endtask

  task automatic test_sweep;
    logic [7:0]  vals [6];
    logic [11:0] exps [6];
    logic [11:0] bcd;
    int lat;
    vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd128, 8'd200};
    exps = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h128, 12'h200};
    i_ready = 1'b1;
    foreach (vals[i]) begin
      run_conv(vals[i], bcd, lat);
      checks++;
      if (bcd !== exps[i]) begin failures++; $display("FAIL sweep_bcd in=%0d got=%h exp=%h", vals[i], bcd, exps[i]); end
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL sweep_latency in=%0d got=%0d exp=8", vals[i], lat); end
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic [11:0] bcd;
    int lat;
    i_ready = 1'b0;
    run_conv(8'd42, bcd, lat);
    checks++;
    if (bcd !== 12'h042) begin failures++; $display("FAIL bp_bcd got=%h exp=042", bcd); end
    for (int k = 0; k < 5; k++) begin
      i_bin = 8'd7;
      i_valid = (k % 2 == 0);
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_bcd !== 12'h042 || o_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%b bcd=%h ready=%b exp valid=1 bcd=042 ready=0", k, o_valid, o_bcd, o_ready);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_handoff valid=%b ready=%b exp valid=0 ready=1", o_valid, o_ready);
    end
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_bcd !== 12'h042) begin
      failures++;
      $display("FAIL bp_no_stray_accept ready=%b bcd=%h exp ready=1 bcd=042", o_ready, o_bcd);
    end
  endtask

  task automatic test_reset_mid_shift;
    logic [11:0] bcd;
    int lat;
    i_ready = 1'b1;
    i_bin = 8'd173;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_bcd !== 12'h000) begin
      failures++;
      $display("FAIL midrst_regs valid=%b bcd=%h exp valid=0 bcd=000", o_valid, o_bcd);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", o_ready); end
    run_conv(8'd61, bcd, lat);
    checks++;
    if (bcd !== 12'h061 || lat !== 8) begin
      failures++;
      $display("FAIL midrst_next bcd=%h lat=%0d exp bcd=061 lat=8", bcd, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [11:0] res [3];
    int t [3];
    int idx, nres;
    logic acc;
    res = '{12'hfff, 12'hfff, 12'hfff};
    t = '{0, 0, 0};
    idx = 0;
    nres = 0;
    i_ready = 1'b1;
    i_bin = 8'd1;
    i_valid = 1'b1;
    for (int cyc = 1; cyc <= 60 && nres < 3; cyc++) begin
      acc = o_ready && i_valid;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) i_bin = 8'(idx + 1);
        else i_valid = 1'b0;
      end
      if (o_valid) begin
        res[nres] = o_bcd;
        t[nres] = cyc;
        nres++;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (nres !== 3 || idx !== 3) begin failures++; $display("FAIL b2b_count results=%0d accepts=%0d exp 3/3", nres, idx); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res[i] !== 12'(i + 1)) begin failures++; $display("FAIL b2b_value idx=%0d got=%h exp=%h", i, res[i], 12'(i + 1)); end
    end
    checks++;
    if (t[1] - t[0] !== 10 || t[2] - t[1] !== 10) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d,%0d exp=10,10", t[1] - t[0], t[2] - t[1]);
    end
    tick();
  endtask

  task automatic test_exhaustive;
    logic [11:0] bcd;
    int lat;
    i_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), bcd, lat);
      checks++;
      if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9 || bcd[11:8] > 4'd9) begin
        failures++;
        $display("FAIL exh_digit_range in=%0d got=%h", v, bcd);
      end
      checks++;
      if (bcd !== ref_bcd(v) || lat !== 8) begin
        failures++;
        $display("FAIL exh_value in=%0d got=%h lat=%0d exp=%h lat=8", v, bcd, lat, ref_bcd(v));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_first_255();
    test_sweep();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_seq_convert.md
Name: bcd_seq_convert

Overview:
- Sequential binary-to-BCD converter built on the shift-and-add-3 (double-dabble) algorithm.
- Accepts one unsigned binary value over a valid/ready handshake and runs one add-3/shift step per clock for BIN_W clocks.
- Presents the packed BCD digits over a valid/ready handshake.
- Sits directly upstream of the counter/display path and feeds it decimal digits for a binary count.

Parameters:
- BIN_W, 8, width of the binary input.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; elaboration-time check errors otherwise.

Ports:
- i_clk, input, 1, single clock; all state changes on its rising edge.
- i_rst, input, 1, synchronous active-high reset.
- i_valid, input, 1, upstream has a value on i_bin.
- o_ready, output, 1, block can accept a value.
- i_bin, input, BIN_W, unsigned binary value to convert.
- o_valid, output, 1, o_bcd holds a completed result.
- i_ready, input, 1, downstream takes the result.
- o_bcd, output, 4*DIGITS, packed BCD digits; most-significant digit in the top nibble.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state IDLE, o_valid=0, o_bcd=0, step counter=0, shift register=0. o_ready=0 while i_rst is high.
- Internal shift register sr: width 4*DIGITS+BIN_W. Upper 4*DIGITS bits are the BCD field; lower BIN_W bits are the binary field.
- Step counter: clog2(BIN_W+1) bits.
- o_ready = (state==IDLE) && !i_rst, decoded combinationally from state.
- IDLE:
  - On i_valid && o_ready: sr <= {0, i_bin}, count <= 0, go to SHIFT (acceptance edge = cycle 0).
  - i_bin is sampled only at this edge; later changes are ignored.
- SHIFT, one step per clock:
  - For each of the DIGITS nibbles of the BCD field: if nibble >= 5, add 3. The 4-bit add cannot overflow, because nibbles are <= 9 before the add.
  - Then shift the whole sr left by 1, inserting 0 at the LSB.
  - count <= count+1.
  - On the edge performing step BIN_W: o_bcd <= BCD field of the post-shift value, o_valid <= 1, go to DONE.
- Latency: o_valid rises BIN_W clocks after the acceptance edge (8 for defaults).
- DONE:
  - o_valid=1; o_bcd held stable until the handshake.
  - On o_valid && i_ready: o_valid <= 0, go to IDLE. o_bcd keeps its last value (no clearing).
  - o_ready=0 in DONE, so a new input is accepted at the earliest on the cycle after handoff.
  - Throughput: one conversion per BIN_W+2 clocks with i_valid and i_ready held high.
- i_valid while o_ready=0: ignored; no internal buffering. Upstream holds data until accepted.
- i_ready while o_valid=0: no effect.
- Reset mid-operation (SHIFT or DONE): conversion aborted; all registers return to reset values on that edge, including o_bcd=0. No partial result is ever flagged valid.
- Illegal or unused state encodings: return to IDLE on the next edge.

Decomposition:
- Shared package:
  - State enum: IDLE, SHIFT, DONE.
  - Constants BCD_DIGIT_W=4, ADD3_THRESHOLD=5, ADD3_VALUE=3.
  - Helper for counter width clog2(BIN_W+1).
- One sub-module: bcd_dabble_step.
  - Purely combinational single iteration: per-digit add-3 correction followed by left shift by 1.
  - Parameterised by DIGITS and BIN_W.
  - Instantiated once and driving sr's next value in SHIFT.
- Top contains only the FSM, counter, sr, and output registers.

Test Plan:
- Reset, then i_bin=255 with i_valid=1 and i_ready=1 -> o_ready drops after acceptance; o_valid rises exactly 8 clocks after the acceptance edge with o_bcd=12'h255; o_ready returns 1 one clock after the handshake.
- Sweep 0, 9, 10, 99, 128, 200 -> o_bcd = 12'h000, 12'h009, 12'h010, 12'h099, 12'h128, 12'h200 respectively; each conversion has latency 8.
- Back-pressure: convert 42 with i_ready=0 for 5 clocks after o_valid -> o_valid stays 1 and o_bcd stays 12'h042 throughout; i_valid pulses with i_bin=7 during this window are ignored; handshake completes when i_ready=1.
- Reset mid-SHIFT: accept 173, assert i_rst after 3 steps -> next edge o_valid=0, o_bcd=0, state IDLE, o_ready=1 once i_rst is released; a following conversion of 61 yields 12'h061 with normal latency.
- Back-to-back: i_valid=1 and i_ready=1 held, inputs 1, 2, 3 presented in sequence -> results 12'h001, 12'h002, 12'h003, spaced 10 clocks apart; no input dropped or duplicated.
- Exhaustive 0..255 against a reference model -> every o_bcd nibble <= 9 and decimal value equals the input.
